exc_seq: RTL and testbench

- Exception/return sequencer on the controller side of the CP0 interface.
- Collects synchronous exception requests (syscall, break, teq), eret, and the external interrupt, then prioritises them.
- Drives CP0's exception/cause/eret strobes.
- After CP0 has registered its exc_addr, stalls the multicycle main FSM and redirects the PC to that address.

---
 rtl/exc_seq.sv | 130 +++++++++++++
 tb/tb_exc_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_seq.sv
// Exception/return sequencer: prioritises syscall/break/teq/eret/interrupt,
// strobes CP0, then stalls the main FSM and redirects the PC to CP0's exc_addr.
module exc_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_done,
  input  logic             req_syscall,
  input  logic             req_break,
  input  logic             req_teq,
  input  logic             req_eret,
  input  logic             intr,
  input  logic [31:0]      status,
  input  logic [31:0]      exc_addr,
  output logic             cp0_exception,
  output logic             cp0_eret,
  output logic [4:0]       cp0_cause,
  output logic             pc_load,
  output logic [31:0]      pc_target,
  output logic             stall,
  output logic             int_pending,
  output logic [CNT_W-1:0] evt_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REDIRECT} state_e;

  localparam logic [4:0] CAUSE_SYS  = 5'b01000;
  localparam logic [4:0] CAUSE_BRK  = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ  = 5'b01101;
  localparam logic [4:0] CAUSE_INT  = 5'b00000;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   pend_q, pend_d;
  logic                   eret_q, eret_d;
  logic [4:0]             cause_q, cause_d;
  logic [31:0]            pc_q, pc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   intr_rise;
  logic                   int_eligible;
  logic                   take_int;
  logic                   unused_status;

  assign unused_status = ^{status[31:9], status[7:1]};

  assign intr_rise    = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  assign int_eligible = pend_q & status[0] & ~status[8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      pend_q      <= 1'b0;
      eret_q      <= 1'b0;
      cause_q     <= '0;
      pc_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], intr};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
      pend_q      <= pend_d;
      eret_q      <= eret_d;
      cause_q     <= cause_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    eret_d   = eret_q;
    cause_d  = cause_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    take_int = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_done) begin
          if (req_eret) begin
            eret_d  = 1'b1;
            state_d = ISSUE;
          end else if (req_syscall) begin
            eret_d  = 1'b0;
            cause_d = CAUSE_SYS;
            state_d = ISSUE;
          end else if (req_break) begin
            eret_d  = 1'b0;
            cause_d = CAUSE_BRK;
            state_d = ISSUE;
          end else if (req_teq) begin
            eret_d  = 1'b0;
            cause_d = CAUSE_TEQ;
            state_d = ISSUE;
          end else if (int_eligible) begin
            eret_d   = 1'b0;
            cause_d  = CAUSE_INT;
            take_int = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        pc_d    = exc_addr;
        state_d = REDIRECT;
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge coinciding with service re-arms the pending flag.
    pend_d = (pend_q & ~take_int) | intr_rise;
  end

  assign cp0_exception = (state_q == ISSUE) & ~eret_q;
  assign cp0_eret      = (state_q == ISSUE) & eret_q;
  assign cp0_cause     = cause_q;
  assign pc_load       = (state_q == REDIRECT);
  assign pc_target     = pc_q;
  assign stall         = (state_q != IDLE);
  assign int_pending   = pend_q;
  assign evt_count     = cnt_q;

endmodule

// File: tb/tb_exc_seq.sv
// Self-checking bench for exc_seq: directed scenarios plus randomized traffic
// compared every cycle against a timestamp-based behavioural model.
module tb_exc_seq;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             instr_done, req_syscall, req_break, req_teq, req_eret, intr;
  logic [31:0]      status, exc_addr;
  logic             cp0_exception, cp0_eret, pc_load, stall, int_pending;
  logic [4:0]       cp0_cause;
  logic [31:0]      pc_target;
  logic [CNT_W-1:0] evt_count;

  always #5 clk = ~clk;

  exc_seq #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr_done(instr_done),
    .req_syscall(req_syscall), .req_break(req_break), .req_teq(req_teq),
    .req_eret(req_eret), .intr(intr), .status(status), .exc_addr(exc_addr),
    .cp0_exception(cp0_exception), .cp0_eret(cp0_eret), .cp0_cause(cp0_cause),
    .pc_load(pc_load), .pc_target(pc_target), .stall(stall),
    .int_pending(int_pending), .evt_count(evt_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the sequence is described by the cycle index of its strobe.
  longint      cyc;
  longint      m_start;
  int unsigned m_taken;
  bit          m_eret;
  bit [4:0]    m_cause;
  bit [31:0]   m_pc;
  bit          m_pend;
  bit          smp[$];
  bit          m_rise, m_take_int, m_busy;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      cyc = 0; m_start = -10; m_taken = 0; m_eret = 0; m_cause = 0; m_pc = 0; m_pend = 0;
      smp = {};
      for (int i = 0; i <= SYNC_STAGES; i++) smp.push_back(1'b0);
    end else begin
      m_rise     = smp[SYNC_STAGES-1] && !smp[SYNC_STAGES];
      m_take_int = 1'b0;
      m_busy     = (cyc - m_start) >= 0 && (cyc - m_start) <= 2;
      if (!m_busy && instr_done) begin
        if (req_eret || req_syscall || req_break || req_teq ||
            (m_pend && status[0] && !status[8])) begin
          m_start = cyc + 1;
          m_taken++;
          m_eret  = req_eret;
          if (!req_eret) begin
            if (req_syscall)    m_cause = 5'd8;
            else if (req_break) m_cause = 5'd9;
            else if (req_teq)   m_cause = 5'd13;
            else begin m_cause = 5'd0; m_take_int = 1'b1; end
          end
        end
      end
      if (cyc - m_start == 1) m_pc = exc_addr;
      m_pend = (m_pend && !m_take_int) || m_rise;
      smp.push_front(intr);
      void'(smp.pop_back());
      cyc++;
    end
  end

  longint           cd;
  logic [CNT_W-1:0] exp_cnt;

  initial forever begin
    @(negedge clk);
    cd      = cyc - m_start;
    exp_cnt = CNT_W'(m_taken - ((cd == 0) ? 1 : 0));
    check("m_exception", 32'(cp0_exception), 32'(cd == 0 && !m_eret));
    check("m_eret",      32'(cp0_eret),      32'(cd == 0 && m_eret));
    check("m_cause",     32'(cp0_cause),     32'(m_cause));
    check("m_pc_load",   32'(pc_load),       32'(cd == 2));
    check("m_pc_target", pc_target,          m_pc);
    check("m_stall",     32'(stall),         32'(cd >= 0 && cd <= 2));
    check("m_int_pend",  32'(int_pending),   32'(m_pend));
    check("m_evt",       32'(evt_count),     32'(exp_cnt));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr();
    instr_done = 0; req_syscall = 0; req_break = 0; req_teq = 0; req_eret = 0;
  endtask

  task automatic syscall_go();
    instr_done = 1; req_syscall = 1;
    tick(); clr();
  endtask

  int unsigned r;

  initial begin
    clr(); intr = 0; status = 0; exc_addr = 0;
    repeat (2) tick();
    check("rst_stall", 32'(stall), 0);
    check("rst_evt", 32'(evt_count), 0);
    check("rst_pc_target", pc_target, 0);
    rst = 1; tick();

    status = 32'h1; exc_addr = 32'h0040_0004;
    syscall_go();
    check("sys_exc", 32'(cp0_exception), 1);
    check("sys_cause", 32'(cp0_cause), 32'h08);
    check("sys_stall1", 32'(stall), 1);
    tick();
    check("sys_stall2", 32'(stall), 1);
    check("sys_evt", 32'(evt_count), 1);
    tick();
    check("sys_pc_load", 32'(pc_load), 1);
    check("sys_pc_target", pc_target, 32'h0040_0004);
    check("sys_stall3", 32'(stall), 1);
    tick();
    check("sys_idle_stall", 32'(stall), 0);

    exc_addr = 32'h0040_0120; instr_done = 1; req_eret = 1;
    tick(); clr();
    check("eret_strobe", 32'(cp0_eret), 1);
    check("eret_no_exc", 32'(cp0_exception), 0);
    tick(); tick();
    check("eret_pc_load", 32'(pc_load), 1);
    check("eret_pc_target", pc_target, 32'h0040_0120);
    tick();

    status = 32'h101; intr = 1;
    tick(); intr = 0;
    tick();
    check("mask_pend_early", 32'(int_pending), 0);
    tick();
    check("mask_pend_set", 32'(int_pending), 1);
    instr_done = 1; tick(); clr();
    check("mask_no_exc", 32'(cp0_exception), 0);
    check("mask_no_stall", 32'(stall), 0);
    check("mask_still_pend", 32'(int_pending), 1);
    status = 32'h1; instr_done = 1; tick(); clr();
    check("int_exc", 32'(cp0_exception), 1);
    check("int_cause", 32'(cp0_cause), 0);
    check("int_pend_clr", 32'(int_pending), 0);
    repeat (3) tick();

    intr = 1; tick(); intr = 0; tick(); tick();
    check("simul_pend", 32'(int_pending), 1);
    instr_done = 1; req_break = 1; tick(); clr();
    check("simul_cause", 32'(cp0_cause), 32'h09);
    check("simul_keep_pend", 32'(int_pending), 1);
    repeat (3) tick();
    instr_done = 1; tick(); clr();
    check("simul_int_exc", 32'(cp0_exception), 1);
    check("simul_int_cause", 32'(cp0_cause), 0);
    repeat (3) tick();

    exc_addr = 32'h0040_0200;
    syscall_go();
    tick();
    #2 rst = 0;
    #1;
    check("rmid_stall", 32'(stall), 0);
    check("rmid_pc_load", 32'(pc_load), 0);
    check("rmid_pc_target", pc_target, 0);
    check("rmid_evt", 32'(evt_count), 0);
    check("rmid_cause", 32'(cp0_cause), 0);
    tick(); rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rmid_no_pc_load", 32'(pc_load), 0);
    end
    exc_addr = 32'h0040_0300; instr_done = 1; req_teq = 1; tick(); clr();
    check("rmid_teq_exc", 32'(cp0_exception), 1);
    check("rmid_teq_cause", 32'(cp0_cause), 32'h0D);
    repeat (3) tick();

    rst = 0; tick(); rst = 1; tick();
    for (int i = 0; i < 17; i++) begin
      syscall_go();
      repeat (3) tick();
    end
    check("wrap_evt", 32'(evt_count), 1);

    syscall_go();
    tick(); tick();
    instr_done = 1; req_teq = 1; tick(); clr();
    check("busy_idle", 32'(stall), 0);
    check("busy_no_exc", 32'(cp0_exception), 0);
    tick();
    check("busy_no_exc2", 32'(cp0_exception), 0);

    for (int i = 0; i < 3000; i++) begin
      clr();
      rst = ($urandom_range(0, 399) != 0);
      instr_done = ($urandom_range(0, 9) < 4);
      r = $urandom_range(0, 9);
      req_eret    = (r == 0);
      req_syscall = (r == 1);
      req_break   = (r == 2) || (r == 4);
      req_teq     = (r == 3) || (r == 4);
      if ($urandom_range(0, 5) == 0) intr = ~intr;
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 3);
        status = (r == 0) ? 32'h1 : (r == 1) ? 32'h101 : (r == 2) ? 32'h0 : 32'h100;
      end
      exc_addr = $urandom;
      tick();
    end
    clr(); rst = 1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
